// File: rtl/noc_packet_pkg.sv
// Hoplite packet layout shared by the injection arbiter and its users.
// x_coord sits in the MSBs and the matrix element in the LSBs.
package noc_packet_pkg;

    localparam int unsigned NOC_COORD_BITS          = 1;
    localparam int unsigned NOC_MULTICAST_GROUP_BITS = 1;
    localparam int unsigned NOC_MATRIX_TYPE_BITS    = 1;
    localparam int unsigned NOC_MATRIX_COORD_BITS   = 8;
    localparam int unsigned NOC_MATRIX_ELEMENT_BITS = 32;

    localparam int unsigned NOC_PACKET_BITS =
        2 * NOC_COORD_BITS + NOC_MULTICAST_GROUP_BITS + 2 + NOC_MATRIX_TYPE_BITS +
        2 * NOC_MATRIX_COORD_BITS + NOC_MATRIX_ELEMENT_BITS;

    // Field LSB offsets, packed from the element upwards
    localparam int unsigned ELEMENT_LSB     = 0;
    localparam int unsigned MATRIX_Y_LSB    = ELEMENT_LSB + NOC_MATRIX_ELEMENT_BITS;
    localparam int unsigned MATRIX_X_LSB    = MATRIX_Y_LSB + NOC_MATRIX_COORD_BITS;
    localparam int unsigned MATRIX_TYPE_LSB = MATRIX_X_LSB + NOC_MATRIX_COORD_BITS;
    localparam int unsigned RESULT_FLAG_LSB = MATRIX_TYPE_LSB + NOC_MATRIX_TYPE_BITS;
    localparam int unsigned DONE_FLAG_LSB   = RESULT_FLAG_LSB + 1;
    localparam int unsigned MULTICAST_LSB   = DONE_FLAG_LSB + 1;
    localparam int unsigned Y_COORD_LSB     = MULTICAST_LSB + NOC_MULTICAST_GROUP_BITS;
    localparam int unsigned X_COORD_LSB     = Y_COORD_LSB + NOC_COORD_BITS;

    typedef struct packed {
        logic [NOC_COORD_BITS-1:0]           x_coord;
        logic [NOC_COORD_BITS-1:0]           y_coord;
        logic [NOC_MULTICAST_GROUP_BITS-1:0] multicast_group;
        logic                                done_flag;
        logic                                result_flag;
        logic [NOC_MATRIX_TYPE_BITS-1:0]     matrix_type;
        logic [NOC_MATRIX_COORD_BITS-1:0]    matrix_x;
        logic [NOC_MATRIX_COORD_BITS-1:0]    matrix_y;
        logic [NOC_MATRIX_ELEMENT_BITS-1:0]  element;
    } noc_packet_t;

    function automatic noc_packet_t unpack_packet(input logic [NOC_PACKET_BITS-1:0] raw);
        return noc_packet_t'(raw);
    endfunction

    function automatic logic [NOC_PACKET_BITS-1:0] pack_packet(input noc_packet_t pkt);
        return NOC_PACKET_BITS'(pkt);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin select; i_rr_ptr names the requester that wins a tie.
module rr_arbiter2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_rr_ptr,
    output logic o_sel,
    output logic o_any_valid
);

    always_comb begin
        o_any_valid = i_valid0 || i_valid1;
        o_sel       = 1'b0;
        if (i_valid0 && i_valid1) begin
            o_sel = i_rr_ptr;
        end else if (i_valid1) begin
            o_sel = 1'b1;
        end
    end

endmodule

// File: rtl/noc_tx_arbiter.sv
// Shares the Hoplite injection port between two packet sources with a
// one-entry output register and debug stall/sent counters.
module noc_tx_arbiter
    import noc_packet_pkg::*;
#(
    parameter int unsigned COORD_BITS           = NOC_COORD_BITS,
    parameter int unsigned MULTICAST_GROUP_BITS = NOC_MULTICAST_GROUP_BITS,
    parameter int unsigned MATRIX_TYPE_BITS     = NOC_MATRIX_TYPE_BITS,
    parameter int unsigned MATRIX_COORD_BITS    = NOC_MATRIX_COORD_BITS,
    parameter int unsigned MATRIX_ELEMENT_BITS  = NOC_MATRIX_ELEMENT_BITS,
    parameter int unsigned PACKET_BITS          = 2 * COORD_BITS + MULTICAST_GROUP_BITS + 2 +
                                                  MATRIX_TYPE_BITS + 2 * MATRIX_COORD_BITS +
                                                  MATRIX_ELEMENT_BITS,
    parameter int unsigned COUNT_BITS           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKET_BITS-1:0] req0_packet,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [PACKET_BITS-1:0] req1_packet,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    output logic [PACKET_BITS-1:0] pkt_out,
    output logic                   pkt_out_valid,
    input  logic                   pkt_out_ready,
    output logic                   pkt_out_src,
    output logic [COUNT_BITS-1:0]  stall_count,
    output logic [COUNT_BITS-1:0]  sent0_count,
    output logic [COUNT_BITS-1:0]  sent1_count
);

    logic [PACKET_BITS-1:0] r_pkt_out;
    logic                   r_pkt_out_valid;
    logic                   r_pkt_out_src;
    logic                   r_rr_ptr;
    logic [COUNT_BITS-1:0]  r_stall_count;
    logic [COUNT_BITS-1:0]  r_sent0_count;
    logic [COUNT_BITS-1:0]  r_sent1_count;

    logic                   w_sel;
    logic                   w_any_valid;
    logic                   w_can_load;
    logic                   w_accept;
    logic                   w_net_accept;
    logic [PACKET_BITS-1:0] w_pkt_in;

    rr_arbiter2 u_rr_arbiter2 (
        .i_valid0    (req0_valid),
        .i_valid1    (req1_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_sel       (w_sel),
        .o_any_valid (w_any_valid)
    );

    // The output register frees up in the same cycle the network takes it
    assign w_can_load   = !r_pkt_out_valid || pkt_out_ready;
    assign w_accept     = !reset && w_can_load && w_any_valid;
    assign w_net_accept = r_pkt_out_valid && pkt_out_ready;
    assign w_pkt_in     = w_sel ? req1_packet : req0_packet;

    assign req0_ready = w_accept && !w_sel;
    assign req1_ready = w_accept && w_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_out       <= '0;
            r_pkt_out_valid <= 1'b0;
            r_pkt_out_src   <= 1'b0;
            r_rr_ptr        <= 1'b0;
        end else if (w_accept) begin
            r_pkt_out       <= w_pkt_in;
            r_pkt_out_valid <= 1'b1;
            r_pkt_out_src   <= w_sel;
            r_rr_ptr        <= ~w_sel;
        end else if (w_net_accept) begin
            r_pkt_out_valid <= 1'b0;
        end
    end

    // Stall counter saturates; sent counters wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_sent0_count <= '0;
            r_sent1_count <= '0;
        end else begin
            if (r_pkt_out_valid && !pkt_out_ready && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + COUNT_BITS'(1);
            end
            if (w_net_accept) begin
                if (r_pkt_out_src) begin
                    r_sent1_count <= r_sent1_count + COUNT_BITS'(1);
                end else begin
                    r_sent0_count <= r_sent0_count + COUNT_BITS'(1);
                end
            end
        end
    end

    assign pkt_out       = r_pkt_out;
    assign pkt_out_valid = r_pkt_out_valid;
    assign pkt_out_src   = r_pkt_out_src;
    assign stall_count   = r_stall_count;
    assign sent0_count   = r_sent0_count;
    assign sent1_count   = r_sent1_count;

endmodule

// File: doc/noc_tx_arbiter.md
Name: noc_tx_arbiter

Overview:
- Shares the node's single Hoplite network injection port between two packet sources: requester 0 (processor memory-mapped packet assembly) and requester 1 (hardware result forwarder).
- Each requester presents a complete packet with a valid/ready handshake. The block grants requesters round-robin and holds the granted packet in an output register until the network accepts it.
- It also exports stall and per-requester sent-packet counters for debug.

Parameters:
- COORD_BITS, 1, width of the x/y destination coordinates
- MULTICAST_GROUP_BITS, 1, width of the multicast group field
- MATRIX_TYPE_BITS, 1, width of the matrix type field
- MATRIX_COORD_BITS, 8, width of the matrix x/y coordinate fields
- MATRIX_ELEMENT_BITS, 32, width of the matrix element field
- PACKET_BITS, 2*COORD_BITS+MULTICAST_GROUP_BITS+2+MATRIX_TYPE_BITS+2*MATRIX_COORD_BITS+MATRIX_ELEMENT_BITS, packed packet width (54 with defaults)
- COUNT_BITS, 16, width of the stall and sent counters

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_packet  in  PACKET_BITS  requester 0 packet
- req0_valid  in  1  requester 0 offers a packet
- req0_ready  out  1  requester 0 packet accepted this cycle when valid
- req1_packet  in  PACKET_BITS  requester 1 packet
- req1_valid  in  1  requester 1 offers a packet
- req1_ready  out  1  requester 1 accept
- pkt_out  out  PACKET_BITS  packet to the network injection port
- pkt_out_valid  out  1  pkt_out holds a packet
- pkt_out_ready  in  1  network accepts pkt_out this cycle (Hoplite deflection free)
- pkt_out_src  out  1  requester that produced the current pkt_out
- stall_count  out  COUNT_BITS  cycles with pkt_out_valid && !pkt_out_ready, saturating
- sent0_count  out  COUNT_BITS  packets from requester 0 accepted by the network, wrapping
- sent1_count  out  COUNT_BITS  packets from requester 1 accepted by the network, wrapping

Behaviour:
- Decided interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: pkt_out=0, pkt_out_valid=0, pkt_out_src=0, rr_ptr=0, all counters=0.
- req*_ready during reset: 0.
- Output register rule:
  - can_load = !pkt_out_valid || pkt_out_ready.
  - State is implicit: EMPTY when pkt_out_valid=0, HOLD when pkt_out_valid=1.
- Arbitration is combinational and evaluated every cycle:
  - Only 0 valid → sel=0. Only 1 valid → sel=1.
  - Both valid → sel = rr_ptr. rr_ptr points at the requester with priority.
  - req{sel}_ready = can_load && req{sel}_valid. The other ready = 0.
  - ready is never asserted without valid being sampled high.
- Accept (req{sel}_valid && req{sel}_ready), at the next edge:
  - pkt_out <= req{sel}_packet; pkt_out_src <= sel; pkt_out_valid <= 1; rr_ptr <= ~sel.
- Network accept (pkt_out_valid && pkt_out_ready) with no new accept in the same cycle: pkt_out_valid <= 0.
- Simultaneous network accept and requester accept: the new packet replaces the old one; pkt_out_valid stays 1. This sustains back-to-back throughput of one packet per cycle.
- Latency: 1 cycle from accepted request to pkt_out_valid.
- While HOLD && !pkt_out_ready: pkt_out and pkt_out_src are stable, and both readys are 0.
- rr_ptr changes only on an accept. A lone requester may be granted repeatedly.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1 from reset.
- Counters:
  - stall_count increments on pkt_out_valid && !pkt_out_ready and saturates at all-ones.
  - sent{pkt_out_src}_count increments on network accept and wraps modulo 2^COUNT_BITS.
- Reset mid-operation: any held packet is discarded (pkt_out_valid=0 next cycle). A requester whose ready was not asserted keeps its packet.
- The block does not inspect or modify packet fields; packing and unpacking are only used for debug visibility.

Decomposition:
- Shared package `noc_packet_pkg`:
  - field width localparams and PACKET_BITS.
  - field offset constants: x, y, multicast group, done flag, result flag, matrix type, matrix x, matrix y, element. Element occupies the LSBs; x_coord occupies the MSBs.
  - pack/unpack functions.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin select from (valid0, valid1, rr_ptr) → sel, any_valid.
- The top level holds the output register and counters.

Test Plan:
- Reset, then req0_valid=1 with packet 0x15_0000_00AB, pkt_out_ready=1 → req0_ready=1 in cycle 0; pkt_out=0x15_0000_00AB, src=0, valid=1 in cycle 1; sent0_count=1 after cycle 1.
- Both requesters valid continuously for 6 cycles, ready=1 → src sequence 0,1,0,1,0,1 on consecutive cycles with no bubbles; sent0=sent1=3.
- Requester 1 packet held with pkt_out_ready=0 for 5 cycles, req0_valid=1 throughout → pkt_out stable, req0_ready=0, stall_count=5; ready=1 → requester 0 accepted in the same cycle, next src=0.
- Stall for 70000 cycles with COUNT_BITS=16 → stall_count saturates at 0xFFFF; sent counters unchanged.
- Assert reset for 1 cycle while a packet is held and req1_valid=1 → pkt_out_valid=0, counters 0, req1_ready=0 during reset; after reset, req1 is granted (rr_ptr=0 but only req1 valid).
- 65537 packets from requester 0 → sent0_count wraps to 1.
